// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_pkg                                                                     |
// | Shared types and constants for the parametrised floating-point multiplier. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fp_pkg;

  // Multiplier sequencing states
  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B,
    MUL_0, MUL_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } fp_state_e;

  // Rounding modes, sampled together with operand B
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // Bit positions inside output_flags
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Exponent bias for a given exponent field width
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN (sign set, exponent all ones, fraction MSB only),
  // right-aligned in 64 bits so callers truncate to their word width
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = (64'd1 << (exp_w + man_w))
      | (((64'd1 << exp_w) - 64'd1) << man_w)
      | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_classify                                                                |
// | Combinational classification of an IEEE-754 magnitude (sign excluded).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] x_mag,
  output logic                   is_nan,
  output logic                   is_snan,
  output logic                   is_inf,
  output logic                   is_zero,
  output logic                   is_denorm
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;

  assign exp_f  = x_mag[EXP_W+MAN_W-1:MAN_W];
  assign frac_f = x_mag[MAN_W-1:0];

  // Field decode; a signalling NaN has the fraction MSB clear
  always_comb begin
    is_nan    = (&exp_f) && (|frac_f);
    is_snan   = is_nan && !frac_f[MAN_W-1];
    is_inf    = (&exp_f) && !(|frac_f);
    is_zero   = !(|exp_f) && !(|frac_f);
    is_denorm = !(|exp_f) && (|frac_f);
  end

endmodule
`default_nettype wire

// File: rtl/fp_mult_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_mult_param                                                              |
// | Multi-cycle IEEE-754 multiplier, any exponent/mantissa format, four        |
// | rounding modes, exception flags, stb/ack operand and result handshakes.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_mult_param import fp_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W:0]     input_a,
  input  logic                     input_a_stb,
  output logic                     input_a_ack,
  input  logic [EXP_W+MAN_W:0]     input_b,
  input  logic                     input_b_stb,
  output logic                     input_b_ack,
  input  logic [1:0]               input_rm,
  output logic [EXP_W+MAN_W:0]     output_z,
  output logic                     output_z_stb,
  input  logic                     output_z_ack,
  output logic [3:0]               output_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M1   = MAN_W + 1;
  localparam int P_W  = 2 * M1;
  // Four spare exponent bits: two denormal operands normalised to their
  // smallest value still sum without wrapping, for every legal format.
  localparam int E_W  = EXP_W + 4;
  localparam int BIAS = fp_bias(EXP_W);

  localparam logic signed [E_W-1:0] BIAS_E = E_W'(BIAS);
  localparam logic signed [E_W-1:0] EMIN_E = E_W'(1 - BIAS);
  localparam logic signed [E_W-1:0] ONE_E  = E_W'(1);

  localparam logic [W-1:0] QNAN    = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] MAX_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  fp_state_e state_q, state_d;

  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic [1:0]             rm_q, rm_d;
  logic                   a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic signed [E_W-1:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic [M1-1:0]          a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic [P_W-1:0]         prod_q, prod_d;
  logic                   guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic                   inexact_q, inexact_d;

  logic                   input_a_ack_q, input_a_ack_d;
  logic                   input_b_ack_q, input_b_ack_d;
  logic                   output_z_stb_q, output_z_stb_d;
  logic [W-1:0]           output_z_q, output_z_d;
  logic [3:0]             output_flags_q, output_flags_d;

  logic a_nan, a_snan, a_inf, a_zero, a_den;
  logic b_nan, b_snan, b_inf, b_zero, b_den;
  logic inc, inx, tiny;
  logic [W-2:0] mag;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
    .x_mag     (a_q[W-2:0]),
    .is_nan    (a_nan),
    .is_snan   (a_snan),
    .is_inf    (a_inf),
    .is_zero   (a_zero),
    .is_denorm (a_den)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
    .x_mag     (b_q[W-2:0]),
    .is_nan    (b_nan),
    .is_snan   (b_snan),
    .is_inf    (b_inf),
    .is_zero   (b_zero),
    .is_denorm (b_den)
  );

  // Next-state, datapath and handshake logic for every sequencing step
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    rm_d           = rm_q;
    a_s_d          = a_s_q;
    b_s_d          = b_s_q;
    z_s_d          = z_s_q;
    a_e_d          = a_e_q;
    b_e_d          = b_e_q;
    z_e_d          = z_e_q;
    a_m_d          = a_m_q;
    b_m_d          = b_m_q;
    z_m_d          = z_m_q;
    prod_d         = prod_q;
    guard_d        = guard_q;
    round_d        = round_q;
    sticky_d       = sticky_q;
    inexact_d      = inexact_q;
    input_a_ack_d  = input_a_ack_q;
    input_b_ack_d  = input_b_ack_q;
    output_z_stb_d = output_z_stb_q;
    output_z_d     = output_z_q;
    output_flags_d = output_flags_q;
    inc            = 1'b0;
    inx            = 1'b0;
    tiny           = 1'b0;
    mag            = '0;

    unique case (state_q)
      GET_A: begin
        input_a_ack_d = 1'b1;
        if (input_a_ack_q && input_a_stb) begin
          a_d           = input_a;
          input_a_ack_d = 1'b0;
          state_d       = GET_B;
        end
      end

      GET_B: begin
        input_b_ack_d = 1'b1;
        if (input_b_ack_q && input_b_stb) begin
          b_d           = input_b;
          rm_d          = input_rm;
          input_b_ack_d = 1'b0;
          state_d       = UNPACK;
        end
      end

      UNPACK: begin
        a_s_d   = a_q[W-1];
        b_s_d   = b_q[W-1];
        a_e_d   = $signed({{(E_W-EXP_W){1'b0}}, a_q[W-2:MAN_W]}) - BIAS_E;
        b_e_d   = $signed({{(E_W-EXP_W){1'b0}}, b_q[W-2:MAN_W]}) - BIAS_E;
        a_m_d   = {1'b0, a_q[MAN_W-1:0]};
        b_m_d   = {1'b0, b_q[MAN_W-1:0]};
        state_d = SPECIAL;
      end

      SPECIAL: begin
        state_d        = PUT_Z;
        output_flags_d = '0;
        if (a_nan || b_nan) begin
          output_z_d              = QNAN;
          output_flags_d[FLG_INV] = a_snan || b_snan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
          output_z_d              = QNAN;
          output_flags_d[FLG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
          output_z_d = {a_s_q ^ b_s_q, INF_MAG};
        end else if (a_zero || b_zero) begin
          output_z_d = {a_s_q ^ b_s_q, {(W-1){1'b0}}};
        end else begin
          // Denormals keep a zero hidden bit and take the minimum exponent
          if (a_den) a_e_d = EMIN_E;
          else       a_m_d[MAN_W] = 1'b1;
          if (b_den) b_e_d = EMIN_E;
          else       b_m_d[MAN_W] = 1'b1;
          if (a_den)      state_d = NORM_A;
          else if (b_den) state_d = NORM_B;
          else            state_d = MUL_0;
        end
      end

      NORM_A: begin
        a_m_d = a_m_q << 1;
        a_e_d = a_e_q - ONE_E;
        if (a_m_q[MAN_W-1]) state_d = b_m_q[MAN_W] ? MUL_0 : NORM_B;
      end

      NORM_B: begin
        b_m_d = b_m_q << 1;
        b_e_d = b_e_q - ONE_E;
        if (b_m_q[MAN_W-1]) state_d = MUL_0;
      end

      MUL_0: begin
        z_s_d   = a_s_q ^ b_s_q;
        z_e_d   = a_e_q + b_e_q + ONE_E;
        prod_d  = P_W'(a_m_q) * P_W'(b_m_q);
        state_d = MUL_1;
      end

      MUL_1: begin
        z_m_d    = prod_q[P_W-1 -: M1];
        guard_d  = prod_q[MAN_W];
        round_d  = prod_q[MAN_W-1];
        sticky_d = |prod_q[MAN_W-2:0];
        state_d  = NORM_1;
      end

      NORM_1: begin
        if (!z_m_q[MAN_W]) begin
          z_m_d   = {z_m_q[MAN_W-1:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
          z_e_d   = z_e_q - ONE_E;
        end else if (z_e_q < EMIN_E) begin
          state_d = NORM_2;
        end else begin
          state_d = ROUND;
        end
      end

      NORM_2: begin
        z_m_d    = z_m_q >> 1;
        guard_d  = z_m_q[0];
        round_d  = guard_q;
        sticky_d = sticky_q | round_q;
        z_e_d    = z_e_q + ONE_E;
        if (z_e_d >= EMIN_E) state_d = ROUND;
      end

      ROUND: begin
        inx = guard_q | round_q | sticky_q;
        case (rm_q)
          RM_RNE:  inc = guard_q & (round_q | sticky_q | z_m_q[0]);
          RM_RUP:  inc = inx & ~z_s_q;
          RM_RDN:  inc = inx & z_s_q;
          default: inc = 1'b0;
        endcase
        if (inc) begin
          if (&z_m_q) begin
            z_m_d = {1'b1, {MAN_W{1'b0}}};
            z_e_d = z_e_q + ONE_E;
          end else begin
            z_m_d = z_m_q + M1'(1);
          end
        end
        inexact_d = inx;
        state_d   = PACK;
      end

      PACK: begin
        output_flags_d = '0;
        if (z_e_q > BIAS_E) begin
          output_flags_d[FLG_OVF] = 1'b1;
          output_flags_d[FLG_INX] = 1'b1;
          case (rm_q)
            RM_RNE:  mag = INF_MAG;
            RM_RTZ:  mag = MAX_MAG;
            RM_RUP:  mag = z_s_q ? MAX_MAG : INF_MAG;
            default: mag = z_s_q ? INF_MAG : MAX_MAG;
          endcase
        end else begin
          tiny = (z_e_q == EMIN_E) && !z_m_q[MAN_W];
          mag  = {tiny ? {EXP_W{1'b0}} : EXP_W'(z_e_q + BIAS_E), z_m_q[MAN_W-1:0]};
          output_flags_d[FLG_UNF] = tiny && inexact_q;
          output_flags_d[FLG_INX] = inexact_q;
        end
        output_z_d = {z_s_q, mag};
        state_d    = PUT_Z;
      end

      PUT_Z: begin
        output_z_stb_d = 1'b1;
        if (output_z_stb_q && output_z_ack) begin
          output_z_stb_d = 1'b0;
          output_flags_d = '0;
          state_d        = GET_A;
        end
      end

      default: state_d = GET_A;
    endcase
  end

  // Control and externally visible registers; reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= GET_A;
      input_a_ack_q  <= 1'b0;
      input_b_ack_q  <= 1'b0;
      output_z_stb_q <= 1'b0;
      output_z_q     <= '0;
      output_flags_q <= '0;
    end else begin
      state_q        <= state_d;
      input_a_ack_q  <= input_a_ack_d;
      input_b_ack_q  <= input_b_ack_d;
      output_z_stb_q <= output_z_stb_d;
      output_z_q     <= output_z_d;
      output_flags_q <= output_flags_d;
    end
  end

  // Working datapath registers; always rewritten before being consumed
  always_ff @(posedge clk) begin
    a_q       <= a_d;
    b_q       <= b_d;
    rm_q      <= rm_d;
    a_s_q     <= a_s_d;
    b_s_q     <= b_s_d;
    z_s_q     <= z_s_d;
    a_e_q     <= a_e_d;
    b_e_q     <= b_e_d;
    z_e_q     <= z_e_d;
    a_m_q     <= a_m_d;
    b_m_q     <= b_m_d;
    z_m_q     <= z_m_d;
    prod_q    <= prod_d;
    guard_q   <= guard_d;
    round_q   <= round_d;
    sticky_q  <= sticky_d;
    inexact_q <= inexact_d;
  end

  assign input_a_ack  = input_a_ack_q;
  assign input_b_ack  = input_b_ack_q;
  assign output_z     = output_z_q;
  assign output_z_stb = output_z_stb_q;
  assign output_flags = output_flags_q;

endmodule
`default_nettype wire
